// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and sizing helpers for the single-port RAM access controller.
// Read responses are flow-controlled by credits.
package sp_ram_ctrl_pkg;

    localparam int unsigned REQ_AW        = 12;
    localparam int unsigned REQ_DW        = 82;
    localparam int unsigned RSP_DEPTH_DEF = 4;
    localparam int unsigned CREDIT_W      = $clog2(RSP_DEPTH_DEF + 1);

    typedef struct packed {
        logic              we;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
    } ram_req_t;

    // Width that holds 0..depth inclusive; used for credits and occupancy.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// Read-response buffer: shift-style synchronous FIFO.
// The head entry and the valid flag come directly from registers.
module sp_ram_rsp_fifo
    import sp_ram_ctrl_pkg::*;
#(
    parameter int unsigned DW    = REQ_DW,
    parameter int unsigned DEPTH = RSP_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DW-1:0]                  din,
    input  logic                           pop,
    output logic [DW-1:0]                  dout,
    output logic                           valid,
    output logic [credit_width(DEPTH)-1:0] count
);

    localparam int unsigned CW = credit_width(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          valid_q;
    logic          do_pop;
    logic          full;
    int unsigned   wr_idx;

    assign do_pop = pop & valid_q;
    assign full   = (count_q == CW'(DEPTH));

    // Entry 0 is always the head; a pop shifts everything down one slot,
    // so a simultaneous push lands one slot lower than the current count.
    always_comb begin
        mem_d  = mem_q;
        wr_idx = 32'(count_q) - 32'(do_pop);
        if (do_pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i == wr_idx) begin
                    mem_d[i] = din;
                end
            end
        end
    end

    assign count_d = count_q + CW'(push) - CW'(do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[0];
    assign valid = valid_q;
    assign count = count_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/sp_ram_access_ctrl.sv
// Request/response front end for a single-port read-first RAM with RD_LAT read latency.
// Read credits guarantee every in-flight read has a reserved response-buffer slot.
module sp_ram_access_ctrl
    import sp_ram_ctrl_pkg::*;
#(
    parameter int unsigned AW        = REQ_AW,
    parameter int unsigned DW        = REQ_DW,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int unsigned CW = credit_width(RSP_DEPTH);

    logic [CW-1:0]     credits_q;
    logic [CW-1:0]     credits_d;
    logic [RD_LAT-1:0] rd_sr_q;
    logic [RD_LAT-1:0] rd_sr_d;
    logic              rd_acc;
    logic              rsp_hs;
    logic [CW-1:0]     rsp_count;

    assign req_ready = !rst && (credits_q != '0);
    assign ram_we    = req_valid & req_ready & req_we;
    assign ram_addr  = req_addr;
    assign ram_din   = req_wdata;

    assign rd_acc = req_valid & req_ready & ~req_we;
    assign rsp_hs = rsp_valid & rsp_ready;

    // Only reads enter the slot tracker, so write slots never push ram_dout.
    always_comb begin
        rd_sr_d    = '0;
        rd_sr_d[0] = rd_acc;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rd_sr_d[i] = rd_sr_q[i - 1];
        end
    end

    always_comb begin
        credits_d = credits_q;
        case ({rd_acc, rsp_hs})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= CW'(RSP_DEPTH);
            rd_sr_q   <= '0;
        end else begin
            credits_q <= credits_d;
            rd_sr_q   <= rd_sr_d;
        end
    end

    sp_ram_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_sr_q[RD_LAT-1]),
        .din   (ram_dout),
        .pop   (rsp_ready),
        .dout  (rsp_rdata),
        .valid (rsp_valid),
        .count (rsp_count)
    );

    a_credit_balance : assert property (@(posedge clk) disable iff (rst)
        (32'(credits_q) + $countones(rd_sr_q) + 32'(rsp_count)) == RSP_DEPTH);

endmodule

// File: tb/tb_sp_ram_access_ctrl.sv
// Directed bench for sp_ram_access_ctrl with a read-first RAM model and an in-order scoreboard.
module tb_sp_ram_access_ctrl;
    import sp_ram_ctrl_pkg::*;

    localparam int unsigned AW = REQ_AW;
    localparam int unsigned DW = REQ_DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic          preload;
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] r1, r2;

    logic [DW-1:0] exp_q [$];
    int            rsp_cyc [$];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_err = 0;
    int            stall_cnt = 0;
    int            k;

    sp_ram_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(2), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first RAM, two register stages from address sample to ram_dout.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            r1 <= mem[ram_addr];
            r2 <= r1;
        end
    end
    assign ram_dout = r2;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
            else chk("rsp_data", rsp_rdata, exp_q.pop_front());
        end
    end

    function automatic ram_req_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram_req_t r;
        r.we = we; r.addr = a; r.wdata = d;
        return r;
    endfunction

    task automatic issue(input ram_req_t r);
        req_valid = 1'b1; req_we = r.we; req_addr = r.addr; req_wdata = r.wdata;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (r.we) ref_mem[r.addr] = r.wdata;
                else exp_q.push_back(ref_mem[r.addr]);
                @(posedge clk); #1;
                return;
            end
            stall_cnt++;
        end
        chk("issue_timeout", req_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #2;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i);
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h7FF; req_wdata = 82'h3;
        rsp_ready = 1'b0;
        @(posedge clk); #1 preload = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        @(posedge clk); #1 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1'b1);
        @(posedge clk); #1;

        // Write then read the same address on the next cycle; check first-read latency.
        rsp_ready = 1'b1;
        issue(mk(1'b1, 12'h010, 82'h0A5));
        issue(mk(1'b0, 12'h010, '0));
        req_valid = 1'b0;
        @(negedge clk); chk("lat_c1", rsp_valid, 1'b0);
        @(negedge clk); chk("lat_c2", rsp_valid, 1'b0);
        @(negedge clk); chk("lat_c3", rsp_valid, 1'b1);
        chk("lat_c3_data", rsp_rdata, 82'h0A5);
        wait_drain();

        // Eight back-to-back reads, responses on consecutive cycles.
        rsp_cyc.delete(); stall_cnt = 0;
        for (int a = 0; a < 8; a++) issue(mk(1'b0, AW'(a), '0));
        req_valid = 1'b0;
        wait_drain();
        chk("b2b_stalls", stall_cnt, 0);
        chk("b2b_rsp_count", rsp_cyc.size(), 8);
        for (int i = 1; i < 8 && i < rsp_cyc.size(); i++) chk("b2b_gap", rsp_cyc[i] - rsp_cyc[i-1], 1);

        // Back-pressure: 6 reads offered with rsp_ready low, only 4 credits.
        rsp_ready = 1'b0; k = 0;
        for (int t = 0; t < 10; t++) begin
            req_valid = (k < 6); req_we = 1'b0; req_addr = AW'(2 + k);
            @(negedge clk);
            if (req_valid && req_ready) begin exp_q.push_back(ref_mem[req_addr]); k++; end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("bp_accepted", k, 4);
        chk("bp_req_ready", req_ready, 1'b0);
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        chk("bp_head", rsp_rdata, 82'h2);
        repeat (2) begin @(negedge clk); chk("bp_hold", rsp_rdata, 82'h2); end
        @(posedge clk); #1 rsp_ready = 1'b1;
        for (int t = 0; t < 30 && k < 6; t++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(2 + k);
            @(negedge clk);
            if (req_ready) begin exp_q.push_back(ref_mem[req_addr]); k++; end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bp_total", k, 6);
        wait_drain();

        // Full buffer, then a response handshake and a read accept in one cycle.
        @(posedge clk); #1 rsp_ready = 1'b0;
        for (int a = 0; a < 4; a++) issue(mk(1'b0, AW'(a), '0));
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("full_req_ready", req_ready, 1'b0);
        chk("full_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("credit_back", req_ready, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h004;
        @(negedge clk);
        chk("both_req_ready", req_ready, 1'b1);
        chk("both_rsp_valid", rsp_valid, 1'b1);
        exp_q.push_back(ref_mem[req_addr]);
        @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("net_zero", req_ready, 1'b1);
        @(posedge clk); #1;
        issue(mk(1'b0, 12'h005, '0));
        req_valid = 1'b0;
        @(negedge clk);
        chk("credit_zero", req_ready, 1'b0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain();

        // Reset with two reads in flight.
        @(posedge clk); #1;
        issue(mk(1'b0, 12'h020, '0));
        issue(mk(1'b0, 12'h021, '0));
        rst = 1'b1; exp_q.delete();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h030; req_wdata = 82'h123;
        #1;
        chk("mid_rst_req_ready", req_ready, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_ram_we", ram_we, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("no_rsp_after_rst", rsp_valid, 1'b0);
        end
        @(posedge clk); #1 rsp_ready = 1'b0; stall_cnt = 0;
        for (int i = 0; i < 4; i++) issue(mk(1'b0, 12'h010, '0));
        req_valid = 1'b0;
        @(negedge clk);
        chk("credits_after_rst", stall_cnt, 0);
        chk("credits_exhausted", req_ready, 1'b0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain();

        // Maximum address, interleaved with address zero.
        @(posedge clk); #1;
        issue(mk(1'b1, 12'hFFF, 82'h2_DEAD_BEEF_1234_5678_9ABC));
        issue(mk(1'b0, 12'hFFF, '0));
        issue(mk(1'b1, 12'h000, 82'h3C3));
        issue(mk(1'b0, 12'hFFF, '0));
        issue(mk(1'b0, 12'h000, '0));
        req_valid = 1'b0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
